// File: rtl/mux_pkg.sv
// Shared constants for the registered round-robin multiplexer.
// Combinational only; no latency.
// No flow control here; encodes the select-mode values.
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_rr_reg_rr_pick.sv
// Round-robin picker: first requester at or after (last+1) mod CHANNELS, with wrap.
// Purely combinational, zero latency.
// No flow control; gnt_any=0 when no request is present.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);
    int k;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = 0;
        // Modulo on int keeps the wrap correct for non-power-of-two channel counts.
        for (int i = 0; i < CHANNELS; i++) begin
            k = (int'(last) + 1 + i) % CHANNELS;
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
    end
endmodule

// File: rtl/mux_rr_reg.sv
// Registered N:1 mux with valid/ready per input, fixed or round-robin select.
// One cycle from input transfer to out_valid; full throughput with out_ready high.
// in_ready drops to all-0 while the output register is held or in reset.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int NPOW = 1 << SEL_W;

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [NPOW-1:0]  valid_ext;
    logic             fix_any;
    logic [SEL_W-1:0] g;
    logic             gnt;
    logic             load;
    logic             xfer;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req     (in_valid),
        .last    (last),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Zero-extended valid lets an out-of-range sel index safely; the range test rejects it.
    assign valid_ext = NPOW'(in_valid);
    assign fix_any   = (int'(sel) < CHANNELS) && valid_ext[sel];

    assign g    = (mode == MODE_RR) ? rr_idx : sel;
    assign gnt  = (mode == MODE_RR) ? rr_any : fix_any;
    assign load = !out_valid || out_ready;
    assign xfer = load && gnt && !reset;

    assign in_ready = xfer ? (CHANNELS'(1) << g) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (xfer) begin
                out_data  <= in_data[g*WIDTH +: WIDTH];
                out_ch    <= g;
                out_valid <= 1'b1;
                last      <= g;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: 4-channel instance plus a 3-channel instance.
// Expected values are hand-computed constants.
module tb_mux_rr_reg;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mux_rr_reg #(.WIDTH(4), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_rr_reg #(.WIDTH(4), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".ch"},    32'(out_ch),    32'(c));
    endtask

    logic [3:0] rr_ch   [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [3:0] rr_dat  [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    logic [3:0] alt_rdy [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [3:0] alt_ch  [4] = '{4'd1, 4'd3, 4'd1, 4'd3};
    logic [3:0] rr3_ch  [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
    logic [3:0] rr3_dat [4] = '{4'hA, 4'hB, 4'hC, 4'hA};

    initial begin
        reset = 1'b1; mode = 1'b0; sel = 2'd0;
        in_data = 16'hDCBA; in_valid = 4'b1111; out_ready = 1'b1;
        mode3 = 1'b1; sel3 = 2'd0; in_data3 = 12'hCBA; in_valid3 = 3'b111; out_ready3 = 1'b1;

        // Reset held two cycles with all inputs valid
        #1;
        chk("rst.in_ready0", 32'(in_ready), 32'b0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out("rst", 1'b0, 4'h0, 2'd0);
            chk("rst.in_ready", 32'(in_ready), 32'b0000);
        end

        // Fixed select
        reset = 1'b0; sel = 2'd2;
        #1;
        chk("fix.rdy_sel2", 32'(in_ready), 32'b0100);
        tick();
        chk_out("fix.c1", 1'b1, 4'hC, 2'd2);
        chk("fix.rdy_again", 32'(in_ready), 32'b0100);
        tick();
        chk_out("fix.c2", 1'b1, 4'hC, 2'd2);
        sel = 2'd0;
        #1;
        chk("fix.rdy_sel0", 32'(in_ready), 32'b0001);
        chk("fix.held_data", 32'(out_data), 32'hC);
        tick();
        chk_out("fix.a", 1'b1, 4'hA, 2'd0);

        // Reset mid-stream discards the held word
        reset = 1'b1;
        tick();
        chk("midrst.valid", 32'(out_valid), 32'd0);
        reset = 1'b0; mode = 1'b1;

        // Round-robin, all valid, back to back
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, rr_dat[i], rr_ch[i][1:0]);
        end

        // Round-robin with sparse requests 1010 (last is 0 here)
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt.rdy%0d", i), 32'(in_ready), 32'(alt_rdy[i]));
            tick();
            chk($sformatf("alt.ch%0d", i), 32'(out_ch), 32'(alt_ch[i]));
        end

        // Backpressure
        reset = 1'b1; in_valid = 4'b1111;
        tick();
        reset = 1'b0;
        #1;
        chk("bp.rdy_first", 32'(in_ready), 32'b0001);
        tick();
        chk_out("bp.a", 1'b1, 4'hA, 2'd0);
        out_ready = 1'b0;
        #1;
        chk("bp.rdy_held", 32'(in_ready), 32'b0000);
        tick();
        chk_out("bp.hold1", 1'b1, 4'hA, 2'd0);
        tick();
        chk_out("bp.hold2", 1'b1, 4'hA, 2'd0);
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_release", 32'(in_ready), 32'b0010);
        tick();
        chk_out("bp.b", 1'b1, 4'hB, 2'd1);
        out_ready = 1'b0;
        tick();
        chk_out("bp.holdb", 1'b1, 4'hB, 2'd1);
        reset = 1'b1;
        #1;
        chk("bp.rdy_rst", 32'(in_ready), 32'b0000);
        tick();
        chk("bp.rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;

        // Fixed select with no grant: held word drains, then idle
        mode = 1'b0; sel = 2'd0;
        #1;
        chk("ng.rdy_load", 32'(in_ready), 32'b0001);
        tick();
        chk_out("ng.a", 1'b1, 4'hA, 2'd0);
        sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
        #1;
        chk("ng.rdy_none", 32'(in_ready), 32'b0000);
        tick();
        chk_out("ng.drain", 1'b0, 4'hA, 2'd0);
        tick();
        chk_out("ng.idle", 1'b0, 4'hA, 2'd0);

        // Three-channel instance: out-of-range select and wrap
        reset = 1'b1;
        tick();
        reset = 1'b0; mode3 = 1'b0; sel3 = 2'd3;
        #1;
        chk("c3.rdy_sel3", 32'(in_ready3), 32'b000);
        tick();
        chk("c3.valid_sel3", 32'(out_valid3), 32'd0);
        sel3 = 2'd2;
        #1;
        chk("c3.rdy_sel2", 32'(in_ready3), 32'b100);
        tick();
        chk("c3.ch_sel2", 32'(out_ch3), 32'd2);
        chk("c3.data_sel2", 32'(out_data3), 32'hC);
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("c3.rr_ch%0d", i), 32'(out_ch3), 32'(rr3_ch[i]));
            chk($sformatf("c3.rr_dat%0d", i), 32'(out_data3), 32'(rr3_dat[i]));
            chk($sformatf("c3.rr_vld%0d", i), 32'(out_valid3), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
